tmr_vote_ctrl: RTL

Registered controller around the 4-bit TMR majority voter (data_1/data_2/data_3 -> tmr_out). It accepts replica triplets through a valid/ready handshake and emits the bitwise-majority word with a per-replica disagreement mask. It tracks consecutive disagreements per replica. When a replica crosses a threshold, it sequences a resync of that replica with a req/ack handshake. It sits between the three redundant producers and the downstream consumer of the voted word.

---
 rtl/tmr_vote_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tmr_vote_ctrl.sv
// Registered TMR majority voter with valid/ready flow control, per-replica
// disagreement streak tracking and a req/ack resync sequencer.
module tmr_vote_ctrl #(
    parameter int WIDTH      = 4,
    parameter int ERR_THRESH = 3,
    parameter int CNT_W      = 8,
    localparam int SW        = $clog2(ERR_THRESH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [WIDTH-1:0] data_3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] tmr_out,
    output logic [2:0]       err_mask,
    output logic [2:0]       resync_req,
    input  logic             resync_ack,
    output logic [CNT_W-1:0] err_cnt_1,
    output logic [CNT_W-1:0] err_cnt_2,
    output logic [CNT_W-1:0] err_cnt_3,
    input  logic             clr_cnt,
    output logic             dbg_state_o,
    output logic [3*SW-1:0]  dbg_streak_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and a held result is stable.
    typedef enum logic {RUN = 1'b0, RESYNC = 1'b1} state_t;

    localparam logic [SW-1:0] THR = SW'(ERR_THRESH);

    state_t           state_q, state_d;
    logic [2:0]       target_q, target_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] tmr_q;
    logic [2:0]       mask_q;
    logic [SW-1:0]    streak_q [3];
    logic [SW-1:0]    streak_d [3];
    logic [CNT_W-1:0] cnt_q [3];
    logic [WIDTH-1:0] vote;
    logic [2:0]       mask;
    logic [2:0]       at_thr_q, at_thr_d;
    logic             accept;

    function automatic logic [2:0] lowest_one(input logic [2:0] v);
        if (v[0])      return 3'b001;
        else if (v[1]) return 3'b010;
        else if (v[2]) return 3'b100;
        else           return 3'b000;
    endfunction

    assign vote   = (data_1 & data_2) | (data_1 & data_3) | (data_2 & data_3);
    assign mask   = {data_3 != vote, data_2 != vote, data_1 != vote};
    assign accept = in_valid & in_ready;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            streak_d[i] = streak_q[i];
            if (accept) begin
                if (!mask[i])               streak_d[i] = '0;
                else if (streak_q[i] != THR) streak_d[i] = streak_q[i] + SW'(1);
            end
            if (state_q == RESYNC && resync_ack && target_q[i]) streak_d[i] = '0;
            at_thr_q[i] = (streak_q[i] == THR);
            at_thr_d[i] = (streak_d[i] == THR);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Next state: a replica still at threshold after an ack re-enters RESYNC
    // straight away because its streak is still visible in RUN.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            RUN: begin
                if (|at_thr_d) begin
                    state_d  = RESYNC;
                    target_d = lowest_one(at_thr_d);
                end
            end
            RESYNC: begin
                if (resync_ack) begin
                    state_d  = RUN;
                    target_d = '0;
                end
            end
            default: begin
                state_d  = RUN;
                target_d = '0;
            end
        endcase
    end

    // Outputs: no accept while any streak sits at threshold, so nothing
    // slips in between two back-to-back resyncs.
    always_comb begin
        in_ready   = !rst && (state_q == RUN) && !(|at_thr_q) && (!out_valid_q || out_ready);
        resync_req = (!rst && state_q == RESYNC) ? target_q : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            tmr_q       <= '0;
            mask_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                streak_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                tmr_q       <= vote;
                mask_q      <= mask;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                streak_q[i] <= streak_d[i];
                if (clr_cnt)                                  cnt_q[i] <= '0;
                else if (accept && mask[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign tmr_out      = tmr_q;
    assign err_mask     = mask_q;
    assign err_cnt_1    = cnt_q[0];
    assign err_cnt_2    = cnt_q[1];
    assign err_cnt_3    = cnt_q[2];
    assign dbg_state_o  = state_q;
    assign dbg_streak_o = {streak_q[2], streak_q[1], streak_q[0]};

endmodule
